// File: rtl/shift_reg_seq_ctrl.sv
// ----------------------------------------------------------------------------
// shift_reg_seq_ctrl
//   Command-driven sequencer for a bidirectional shift register datapath.
//   One job is accepted per cmd handshake. The sequencer pulses the datapath
//   enable once per step and feeds one serial bit per step. It captures the bit
//   leaving the register on each step and returns the captured bits on the rsp
//   handshake.
//
//   The datapath must shift on the same posedge that samples sh_en = 1. With
//   mode = 1 it shifts toward bit 0 and dr enters the MSB. With mode = 0 it
//   shifts toward the MSB and dl enters bit 0.
//
// Configuration macro: SHIFT_CTRL_ROTATE_EN
//   When defined, the cmd_rot input is added. A job accepted with cmd_rot = 1
//   feeds each leaving bit back in as the serial input, so the register
//   rotates and cmd_data is ignored.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_dir               1: shift toward bit 0, 0: shift toward MSB
//   cmd_len               number of shifts (clamped to WIDTH)
//   cmd_data              serial bits, bit i injected on step i
//   cmd_rot               rotate job (SHIFT_CTRL_ROTATE_EN only)
//   sh_q                  parallel output of the shift register
//   sh_en, mode, dr, dl   datapath controls (registered)
//   busy                  job in flight (SHIFT or DONE)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              captured bits, bit i = bit that left on step i
// ----------------------------------------------------------------------------
module shift_reg_seq_ctrl #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef SHIFT_CTRL_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic [WIDTH-1:0] sh_q,
    output logic             sh_en,
    output logic             mode,
    output logic             dr,
    output logic             dl,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] len_q;
    // Remaining serial bits; the bit for the next step is always data_q[0].
    logic [WIDTH-1:0] data_q;
`ifdef SHIFT_CTRL_ROTATE_EN
    logic             rot_q;
`endif

    logic [CNT_W-1:0] len_c;
    logic             lead_cur_c;
    logic             first_bit_c;
    logic             next_bit_c;
    logic             unused_sh_q_c;

    // Length clamp, the leaving bit, and the serial bit for the next step.
    always_comb begin
        len_c      = (cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_len;
        lead_cur_c = mode ? sh_q[0] : sh_q[WIDTH-1];
`ifdef SHIFT_CTRL_ROTATE_EN
        // In rotate mode the next leaving bit is the neighbour of the current
        // leaving bit, because the shift happens on the edge that loads dr or dl.
        first_bit_c = cmd_rot ? (cmd_dir ? sh_q[0] : sh_q[WIDTH-1]) : cmd_data[0];
        next_bit_c  = rot_q ? (mode ? sh_q[1] : sh_q[WIDTH-2]) : data_q[0];
`else
        first_bit_c = cmd_data[0];
        next_bit_c  = data_q[0];
`endif
    end

    assign unused_sh_q_c = ^sh_q;

    // Sequencer FSM with registered datapath controls and handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            len_q     <= '0;
            data_q    <= '0;
`ifdef SHIFT_CTRL_ROTATE_EN
            rot_q     <= 1'b0;
`endif
            sh_en     <= 1'b0;
            mode      <= 1'b0;
            dr        <= 1'b0;
            dl        <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mode      <= cmd_dir;
                        len_q     <= len_c;
                        data_q    <= cmd_data >> 1;
`ifdef SHIFT_CTRL_ROTATE_EN
                        rot_q     <= cmd_rot;
`endif
                        step      <= '0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (len_c == '0) begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                            sh_en <= 1'b1;
                            dr    <= cmd_dir & first_bit_c;
                            dl    <= ~cmd_dir & first_bit_c;
                        end
                    end
                end
                S_SHIFT: begin
                    // sh_q still holds the pre-shift value at this edge.
                    rsp_data[IDX_W'(step)] <= lead_cur_c;
                    if (step == len_q - CNT_W'(1)) begin
                        state     <= S_DONE;
                        sh_en     <= 1'b0;
                        dr        <= 1'b0;
                        dl        <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        step   <= step + CNT_W'(1);
                        data_q <= data_q >> 1;
                        dr     <= mode & next_bit_c;
                        dl     <= ~mode & next_bit_c;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_reg_seq_ctrl
//   Drives shift jobs into shift_reg_seq_ctrl around a simple shift register
//   datapath. Expected outputs come from closed-form job arithmetic.
// ----------------------------------------------------------------------------
module tb_shift_reg_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_len;
    logic [W-1:0]  cmd_data;
    logic          cmd_rot;
    logic [W-1:0]  sh_q;
    logic          sh_en;
    logic          mode;
    logic          dr;
    logic          dl;
    logic          busy;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;

    // Datapath register with a bench-side parallel load for test setup.
    logic [W-1:0]  sh_reg;
    logic          load;
    logic [W-1:0]  load_val;

    // Expected outputs for the current cycle.
    logic          chk_en;
    logic          e_ready_chk;
    logic          e_cmd_ready;
    logic          e_busy;
    logic          e_sh_en;
    logic          e_rsp_valid;
    logic          e_dr;
    logic          e_dl;
    logic          e_mode;
    logic          e_mode_chk;
    logic          e_rsp_chk;
    logic [W-1:0]  e_rsp;
    logic          e_reg_chk;
    logic [W-1:0]  e_reg;
    logic          lit_en;
    logic [W-1:0]  lit_reg;
    logic [W-1:0]  lit_rsp;

    int checks   = 0;
    int failures = 0;

    shift_reg_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
`ifdef SHIFT_CTRL_ROTATE_EN
        .cmd_rot   (cmd_rot),
`endif
        .sh_q      (sh_q),
        .sh_en     (sh_en),
        .mode      (mode),
        .dr        (dr),
        .dl        (dl),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load)
            sh_reg <= load_val;
        else if (sh_en)
            sh_reg <= mode ? {dr, sh_reg[W-1:1]} : {sh_reg[W-2:0], dl};
    end
    assign sh_q = sh_reg;

    // Bits leaving on steps 0..len-1, packed with step i at bit i.
    function automatic logic [W-1:0] model_rsp(input logic [W-1:0] r, input logic dir,
                                               input int unsigned len);
        logic [W-1:0] q;
        q = '0;
        for (int i = 0; i < int'(len); i++)
            q[i] = dir ? r[i] : r[W-1-i];
        return q;
    endfunction

    // Register contents after the job.
    function automatic logic [W-1:0] model_final(input logic [W-1:0] r, input logic dir,
                                                 input int unsigned len, input logic [W-1:0] d,
                                                 input logic rot);
        logic [2*W-1:0] rr;
        int unsigned    rv;
        int unsigned    dm;
        int unsigned    rev;
        int unsigned    res;
        rr  = {r, r};
        rv  = 32'(r);
        dm  = 32'(d) & ((32'd1 << len) - 32'd1);
        rev = 0;
        if (rot)
            return dir ? W'(rr >> len) : W'((rr << len) >> W);
        if (dir) begin
            res = (rv >> len) | (dm << (32'(W) - len));
        end else begin
            for (int i = 0; i < int'(len); i++)
                if (d[i]) rev = rev | (32'd1 << (len - 1 - 32'(i)));
            res = ((rv << len) & ((32'd1 << W) - 32'd1)) | rev;
        end
        return W'(res);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: checks every output against the expectations each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (e_ready_chk) chk("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("sh_en", 32'(sh_en), 32'(e_sh_en));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            chk("dr", 32'(dr), 32'(e_dr));
            chk("dl", 32'(dl), 32'(e_dl));
            if (e_mode_chk) chk("mode", 32'(mode), 32'(e_mode));
            if (e_rsp_chk)  chk("rsp_data", 32'(rsp_data), 32'(e_rsp));
            if (e_reg_chk)  chk("final_reg", 32'(sh_reg), 32'(e_reg));
            if (lit_en) begin
                chk("lit_reg", 32'(sh_reg), 32'(lit_reg));
                chk("lit_rsp", 32'(rsp_data), 32'(lit_rsp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_cmd_ready = 1'b1;
        e_busy      = 1'b0;
        e_sh_en     = 1'b0;
        e_rsp_valid = 1'b0;
        e_dr        = 1'b0;
        e_dl        = 1'b0;
        e_rsp_chk   = 1'b0;
        e_reg_chk   = 1'b0;
        lit_en      = 1'b0;
    endtask

    task automatic load_reg(input logic [W-1:0] v);
        load_val = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic set_shift(input logic dir, input logic b);
        e_cmd_ready = 1'b0;
        e_busy      = 1'b1;
        e_sh_en     = 1'b1;
        e_rsp_valid = 1'b0;
        e_mode      = dir;
        e_mode_chk  = 1'b1;
        e_dr        = dir & b;
        e_dl        = ~dir & b;
    endtask

    // One complete job: accept, shift steps, DONE hold, response handshake.
    task automatic run_job(input logic dir, input int unsigned len_in, input logic [W-1:0] data,
                           input logic rot, input int hold, input logic lit_on,
                           input logic [W-1:0] l_reg, input logic [W-1:0] l_rsp);
        int unsigned  len;
        logic [W-1:0] r0;
        logic         b;
        len       = (len_in > W) ? W : len_in;
        r0        = sh_reg;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = CW'(len_in);
        cmd_data  = data;
        cmd_rot   = rot;
        tick();
        for (int k = 0; k < int'(len); k++) begin
            // A rotating job feeds back the bit that leaves on this step.
            b = rot ? (dir ? r0[k] : r0[W-1-k]) : data[k];
            set_shift(dir, b);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_len   = CW'($urandom_range(0, 7));
            cmd_data  = W'($urandom);
            cmd_rot   = 1'b0;
            tick();
        end
        e_cmd_ready = 1'b0;
        e_busy      = 1'b1;
        e_sh_en     = 1'b0;
        e_rsp_valid = 1'b1;
        e_dr        = 1'b0;
        e_dl        = 1'b0;
        e_rsp_chk   = 1'b1;
        e_rsp       = model_rsp(r0, dir, len);
        e_reg_chk   = 1'b1;
        e_reg       = model_final(r0, dir, len, data, rot);
        lit_en      = lit_on;
        lit_reg     = l_reg;
        lit_rsp     = l_rsp;
        if (len == 0) e_mode_chk = 1'b0;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_len   = CW'($urandom_range(1, 4));
            cmd_data  = W'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rnd_data;
        logic         rnd_rot;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        cmd_rot   = 1'b0;
        rsp_ready = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        chk_en    = 1'b0;
        set_idle();
        e_ready_chk = 1'b0;
        e_mode      = 1'b0;
        e_mode_chk  = 1'b1;
        e_rsp       = '0;
        #2 rst = 1'b1;

        // Reset state.
        tick();
        e_rsp_chk = 1'b1;
        chk_en    = 1'b1;
        tick();
        rst         = 1'b0;
        e_ready_chk = 1'b1;
        tick();
        e_rsp_chk = 1'b0;

        // Right shift of a full word into a cleared register.
        load_reg(4'b0000);
        run_job(1'b1, 4, 4'b1011, 1'b0, 0, 1'b1, 4'b1011, 4'b0000);

        // Reset after two of four steps aborts the job.
        load_reg(4'b1100);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_len   = CW'(4);
        cmd_data  = 4'b1010;
        cmd_rot   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        set_shift(1'b1, 1'b0);
        tick();
        set_shift(1'b1, 1'b1);
        tick();
        rst = 1'b1;
        set_idle();
        e_ready_chk = 1'b0;
        e_mode      = 1'b0;
        e_mode_chk  = 1'b1;
        e_rsp       = '0;
        e_rsp_chk   = 1'b1;
        tick();
        tick();
        rst         = 1'b0;
        e_ready_chk = 1'b1;
        repeat (4) tick();
        e_rsp_chk = 1'b0;

        // Left shift of two bits.
        load_reg(4'b1001);
        run_job(1'b0, 2, 4'b0011, 1'b0, 0, 1'b1, 4'b0111, 4'b0001);

        // Zero length and an over-long length.
        load_reg(4'b1010);
        run_job(1'b1, 0, 4'b1111, 1'b0, 0, 1'b1, 4'b1010, 4'b0000);
        load_reg(4'b1100);
        run_job(1'b0, 7, 4'b0001, 1'b0, 0, 1'b1, 4'b1000, 4'b0011);

        // Response held off for five cycles while new commands are offered.
        load_reg(4'b0110);
        run_job(1'b1, 3, 4'b0101, 1'b0, 5, 1'b1, 4'b1010, 4'b0110);

`ifdef SHIFT_CTRL_ROTATE_EN
        // Full rotation restores the register.
        load_reg(4'b0110);
        run_job(1'b1, 4, 4'b1001, 1'b1, 0, 1'b1, 4'b0110, 4'b0110);
        load_reg(4'b0011);
        run_job(1'b0, 4, 4'b1111, 1'b1, 0, 1'b1, 4'b0011, 4'b1100);
`endif

        // Random jobs.
        for (int j = 0; j < 40; j++) begin
            load_reg(W'($urandom));
            rnd_data = W'($urandom);
            rnd_rot  = 1'b0;
`ifdef SHIFT_CTRL_ROTATE_EN
            rnd_rot  = 1'($urandom_range(0, 1));
`endif
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd_data, rnd_rot,
                    int'($urandom_range(0, 3)), 1'b0, '0, '0);
            repeat ($urandom_range(0, 2)) tick();
        end

        chk_en = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
